// File: rtl/max31855_pkg.sv
`default_nettype none
// ============================================================================
// Module   : max31855_pkg
// Purpose  : Shared frame layout, FSM state type and frame packing helper
//            for the MAX31855 SPI responder model.
// Revision : 1.0  initial release
// ============================================================================
package max31855_pkg;

    localparam int FRAME_BITS = 32;
    localparam int TC_BITS    = 14;
    localparam int JT_BITS    = 12;
    localparam int FAULT_BITS = 3;

    localparam int TC_MSB     = 31;
    localparam int TC_LSB     = 18;
    localparam int FAULT_BIT  = 16;
    localparam int JT_MSB     = 15;
    localparam int JT_LSB     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    // Reserved bits 17 and 3 stay zero; bit 16 summarises all fault flags.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [TC_BITS-1:0]    tc,
        input logic [JT_BITS-1:0]    jt,
        input logic [FAULT_BITS-1:0] faults
    );
        logic [FRAME_BITS-1:0] f;
        f                  = '0;
        f[TC_MSB:TC_LSB]   = tc;
        f[FAULT_BIT]       = |faults;
        f[JT_MSB:JT_LSB]   = jt;
        f[FAULT_BITS-1:0]  = faults;
        return f;
    endfunction

endpackage : max31855_pkg
`default_nettype wire

// File: rtl/max31855_emulator_spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_edge_sync
// Purpose  : Multi-stage synchronizer for an asynchronous SPI pin, plus a
//            previous-sample register yielding level, rise and fall strobes.
// Revision : 1.0  initial release
// ============================================================================
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule : spi_edge_sync
`default_nettype wire

// File: rtl/max31855_emulator.sv
`default_nettype none
// ============================================================================
// Module   : max31855_emulator
// Purpose  : Sensor-side MAX31855 model: snapshots temperature/fault inputs
//            while CS is idle and shifts the 32-bit frame out on MISO.
// Revision : 1.0  initial release
// ============================================================================
module max31855_emulator
    import max31855_pkg::*;
#(
    parameter int CONV_CYCLES = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  sck,
    input  logic [TC_BITS-1:0]    tc_temp_in,
    input  logic [JT_BITS-1:0]    junction_temp_in,
    input  logic [FAULT_BITS-1:0] fault_in,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  conv_busy,
    output logic [7:0]            frame_count
);

    localparam int c_cnt_w = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_conv_last = c_cnt_w'(CONV_CYCLES - 1);
    localparam logic [4:0] c_bit_top = 5'(FRAME_BITS - 1);

    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_level;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_unused_sck;

    logic [c_cnt_w-1:0]    r_conv_cnt;
    logic                  r_conv_busy;
    logic [FRAME_BITS-1:0] r_frame;

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_bit_cnt;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic [7:0]            r_frame_count;

    // cs_n idles high, so its synchronizer resets high to avoid a false fall.
    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // Mode 0 responder: data changes on falling SCK only.
    assign w_unused_sck = w_sck_level ^ w_sck_rise;

    // Conversion: run while CS idles high, snapshot once, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_cnt  <= '0;
            r_conv_busy <= 1'b1;
            r_frame     <= '0;
        end else if (w_cs_rise) begin
            r_conv_cnt  <= '0;
            r_conv_busy <= 1'b1;
        end else if (w_cs_fall) begin
            r_conv_cnt  <= '0;
        end else if (w_cs_level && r_conv_busy) begin
            if (r_conv_cnt == c_conv_last) begin
                r_frame     <= pack_frame(tc_temp_in, junction_temp_in, fault_in);
                r_conv_busy <= 1'b0;
            end else begin
                r_conv_cnt  <= r_conv_cnt + 1'b1;
            end
        end
    end

    // Transfer FSM; a CS rise pre-empts any same-cycle SCK fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_count <= '0;
        end else if (w_cs_rise) begin
            if (r_state == DONE) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            r_state   <= IDLE;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_shift   <= r_frame;
                        r_bit_cnt <= c_bit_top;
                        r_miso    <= r_frame[FRAME_BITS-1];
                        r_miso_oe <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_sck_fall) begin
                        if (r_bit_cnt == 5'd0) begin
                            r_miso  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            r_miso    <= r_shift[FRAME_BITS-2];
                        end
                    end
                end
                DONE: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_miso    <= 1'b0;
                    r_miso_oe <= 1'b0;
                end
            endcase
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_miso_oe;
    assign conv_busy   = r_conv_busy;
    assign frame_count = r_frame_count;

endmodule : max31855_emulator
`default_nettype wire

// File: tb/tb_max31855_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_max31855_emulator
// Purpose  : Randomised SPI-master bench for max31855_emulator with a
//            transaction-level frame/count model and a per-cycle MISO_OE check.
// Revision : 1.0  initial release
// ============================================================================
module tb_max31855_emulator;

    localparam int CONV_CYCLES = 10;
    localparam int SYNC_STAGES = 2;
    localparam int HALF_MIN    = SYNC_STAGES + 3;
    localparam int LONG_IDLE   = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [13:0] tc = '0;
    logic [11:0] jt = '0;
    logic [2:0]  flt = '0;
    logic        miso;
    logic        miso_oe;
    logic        conv_busy;
    logic [7:0]  frame_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_frame = '0;
    int          exp_count = 0;
    bit          wrapped = 1'b0;
    logic [31:0] got;

    always #5 clk = ~clk;

    max31855_emulator #(
        .CONV_CYCLES (CONV_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cs_n             (cs_n),
        .sck              (sck),
        .tc_temp_in       (tc),
        .junction_temp_in (jt),
        .fault_in         (flt),
        .miso             (miso),
        .miso_oe          (miso_oe),
        .conv_busy        (conv_busy),
        .frame_count      (frame_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Frame value from field weights: tc*2^18 + anyfault*2^16 + jt*2^4 + faults.
    function automatic logic [31:0] model_frame(input logic [13:0] t, input logic [11:0] j,
                                                input logic [2:0] f);
        longint v;
        v = longint'(t) * 262144 + ((f != 3'b000) ? 65536 : 0) + longint'(j) * 16 + longint'(f);
        return v[31:0];
    endfunction

    // miso_oe must follow the cs_n pin delayed by the synchronizer plus one register.
    logic cs_hist [0:SYNC_STAGES];
    bit   hist_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= SYNC_STAGES; i++) cs_hist[i] <= 1'b1;
            hist_ok <= 1'b1;
        end else begin
            cs_hist[0] <= cs_n;
            for (int i = 1; i <= SYNC_STAGES; i++) cs_hist[i] <= cs_hist[i-1];
        end
    end

    always @(negedge clk) begin
        if (hist_ok) begin
            check("miso_oe_track", 32'(miso_oe), 32'(!cs_hist[SYNC_STAGES]));
            if (cs_hist[SYNC_STAGES]) check("miso_idle_zero", 32'(miso), 32'd0);
        end
    end

    // One CS window: idle high, then nbits SCK clocks; master samples before each rise.
    task automatic read_frame(input int idle, input int nbits, input int half,
                              input int rst_at, input bit coincide, output logic [31:0] word);
        bit long_idle;
        long_idle = (idle >= LONG_IDLE);
        word = '0;
        repeat (idle) @(negedge clk);
        check("busy_at_cs_fall", 32'(conv_busy), long_idle ? 32'd0 : 32'd1);
        if (long_idle) exp_frame = model_frame(tc, jt, flt);
        cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 1; i <= nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_oe", 32'(miso_oe), 32'd0);
                check("rst_miso", 32'(miso), 32'd0);
                check("rst_count", 32'(frame_count), 32'd0);
                check("rst_busy", 32'(conv_busy), 32'd1);
                cs_n = 1'b1;
                sck  = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                exp_frame = '0;
                exp_count = 0;
                return;
            end
            check($sformatf("bit%0d", i), 32'(miso), (i <= 32) ? 32'(exp_frame[32-i]) : 32'd0);
            if (i <= 32) word[32-i] = miso;
            sck = 1'b1;
            tc  = 14'($urandom);
            jt  = 12'($urandom);
            flt = 3'($urandom);
            repeat (half) @(negedge clk);
            if (coincide && i == nbits) begin
                sck  = 1'b0;
                cs_n = 1'b1;
            end else begin
                sck = 1'b0;
                repeat (half) @(negedge clk);
            end
        end
        cs_n = 1'b1;
        if (nbits >= 32 && !coincide) begin
            exp_count = (exp_count + 1) % 256;
            if (exp_count == 0) wrapped = 1'b1;
        end
        repeat (SYNC_STAGES + 2) @(negedge clk);
        check("frame_count", 32'(frame_count), 32'(exp_count));
    endtask

    task automatic set_in(input logic [13:0] t, input logic [11:0] j, input logic [2:0] f);
        tc = t; jt = j; flt = f;
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_oe", 32'(miso_oe), 32'd0);
        check("reset_busy", 32'(conv_busy), 32'd1);
        check("reset_count", 32'(frame_count), 32'd0);
        rst = 1'b0;

        // CS falls before the first conversion: frame_reg is still zero.
        read_frame(3, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_after_reset", got, 32'h0000_0000);

        rst = 1'b1;
        exp_count = 0;
        exp_frame = '0;
        set_in(14'h0640, 12'h190, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (CONV_CYCLES - 1) @(negedge clk);
        check("first_conv_busy", 32'(conv_busy), 32'd1);
        @(negedge clk);
        check("first_conv_done", 32'(conv_busy), 32'd0);

        read_frame(16, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_plain", got, 32'h1900_1900);
        set_in(14'h0640, 12'h190, 3'b001);
        read_frame(16, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_oc", got, 32'h1901_1901);
        set_in(14'h0640, 12'h190, 3'b100);
        read_frame(16, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_scv", got, 32'h1901_1904);
        set_in(14'h3FFC, 12'hFF0, 3'b000);
        read_frame(16, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_neg", got, 32'hFFF0_FF00);
        set_in(14'h0123, 12'h456, 3'b010);
        read_frame(1, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_aborted_conv", got, 32'hFFF0_FF00);

        set_in(14'h2AAA, 12'h555, 3'b011);
        read_frame(16, 40, HALF_MIN, 0, 1'b0, got);
        read_frame(16, 10, HALF_MIN, 0, 1'b0, got);
        read_frame(16, 32, HALF_MIN, 0, 1'b1, got);

        for (int n = 0; n < 20; n++) begin
            int idle, nbits, sel;
            set_in(14'($urandom), 12'($urandom), 3'($urandom));
            idle  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1)
                                                : $urandom_range(LONG_IDLE, LONG_IDLE + 4);
            sel   = $urandom_range(0, 9);
            nbits = (sel < 2) ? $urandom_range(1, 31) : (sel < 3) ? $urandom_range(33, 36) : 32;
            read_frame(idle, nbits, $urandom_range(HALF_MIN, HALF_MIN + 1), 0, 1'b0, got);
        end

        guard = 0;
        while (!wrapped && guard < 300) begin
            read_frame(0, 32, HALF_MIN, 0, 1'b0, got);
            guard++;
        end
        check("wrap_reached", 32'(wrapped), 32'd1);

        set_in(14'h1111, 12'h222, 3'b000);
        read_frame(16, 32, HALF_MIN, 15, 1'b0, got);
        read_frame(1, 32, HALF_MIN, 0, 1'b0, got);
        check("frame_after_mid_rst", got, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_max31855_emulator
`default_nettype wire

// File: doc/max31855_emulator.md
# max31855_emulator

Sensor-side model of a MAX31855-style thermocouple-to-digital converter, i.e. the SPI responder that the thermocouple readout controller reads. It periodically converts (snapshots) temperature and fault inputs into a 32-bit frame and shifts that frame out on MISO while the master holds chip-select low. It serves as a synthesizable stand-in for the real chip in simulation and on the FPGA test board.

## Interface
- CONV_CYCLES, 10: clk cycles of CS-high idle required to complete one conversion (snapshot).
- SYNC_STAGES, 2: flip-flop stages in each cs_n/sck input synchronizer (≥2).
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset rst, synchronous, active-high; clock clk.
- cs_n  input  1  SPI chip select from the master, active-low, asynchronous to clk.
- sck  input  1  SPI clock from the master, mode 0, asynchronous to clk.
- tc_temp_in  input  14  thermocouple temperature, two's complement, 0.25 °C/LSB.
- junction_temp_in  input  12  cold-junction temperature, two's complement, 0.0625 °C/LSB.
- fault_in  input  3  {SCV, SCG, OC} fault flags.
- miso  output  1  serial data to the master.
- miso_oe  output  1  MISO output enable; high only while the synchronized cs_n is low.
- conv_busy  output  1  high while a conversion is in progress.
- frame_count  output  8  number of completed 32-bit transfers, wraps at 255→0.

## Operation
- Frame layout: [31:18] tc_temp, [17] 0, [16] OR of fault bits, [15:4] junction_temp, [3] 0, [2:0] {SCV,SCG,OC}.
- Conversion counter conv_cnt counts clk cycles while synchronized cs_n is high; it clears when cs_n falls.
- When conv_cnt reaches CONV_CYCLES-1: snapshot the inputs into frame_reg; conv_busy drops; the counter holds.
- A CS falling edge before the conversion completes aborts it: frame_reg keeps the previous snapshot (all zeros after reset).
- State machine with three states:
  - IDLE: cs_n high, converting or converted.
  - SHIFT: on CS fall, load shift_reg←frame_reg, set bit_cnt=31, drive miso=frame bit 31, assert miso_oe.
    - On each synchronized SCK falling edge: shift left, decrement bit_cnt, drive the next bit.
    - SCK rising edges are ignored; the master samples on the rising edge.
  - DONE: entered after the falling edge that follows bit 0; miso=0 for any further clocks.
- CS rising edge in any state: miso_oe=0, miso=0, return to IDLE, restart conversion.
  - frame_count increments only if DONE was reached. A partial transfer does not count.
- Simultaneous CS rise and SCK fall: the CS rise wins and no shift occurs.
- Input changes outside a snapshot cycle never affect a frame in flight.

## Timing
- Reset values: miso=0, miso_oe=0, conv_busy=1, frame_count=0, frame_reg=0, conv_cnt=0, state IDLE.
  - Synchronizer stages reset to cs_n=1 and sck=0.
- Reset mid-transfer aborts immediately: outputs go to their reset values, and the transfer is not counted.
- Pin-to-edge latency is SYNC_STAGES+1 clk cycles for both cs_n and sck edges. miso/miso_oe are registered and update the cycle after edge detection.
- Master requirements:
  - SCK high and low phases ≥ SYNC_STAGES+3 clk cycles each.
  - CS-fall to first SCK rise ≥ SYNC_STAGES+3 cycles.
- First conversion completes CONV_CYCLES cycles after rst deasserts while cs_n stays high.

## Structure
- Package max31855_pkg holds:
  - FRAME_BITS=32.
  - Field-position localparams (TC_MSB=31, TC_LSB=18, FAULT_BIT=16, JT_MSB=15, JT_LSB=4).
  - The state enum {IDLE, SHIFT, DONE}.
  - Function pack_frame(tc, jt, faults) returning the 32-bit frame.
- One sub-module, spi_edge_sync: a SYNC_STAGES synchronizer plus previous-sample register, producing level, rise and fall. It is instantiated twice, for cs_n and sck.

## Test plan
- tc=14'h0640, jt=12'h190, faults=0; wait past conversion, read 32 bits → 32'h1900_1900, frame_count=1.
- Same temperatures with OC=1 → 32'h1901_1901; with SCV=1 instead → 32'h1901_1904.
- Negative values tc=14'h3FFC (−1 °C), jt=12'hFF0 (−1 °C) → 32'hFFF0_FF00.
- CS falls only CONV_CYCLES/2 cycles after a prior read; inputs have changed meanwhile → the old frame is returned; conv_busy was high at the CS fall.
- 40 SCK clocks in one CS-low window → the first 32 bits are the frame, bits 33-40 are 0, frame_count +1. Abort after 10 bits → frame_count unchanged. rst at bit 15 → miso_oe=0 the next cycle.
- 256 complete reads → frame_count wraps to 0; miso_oe is never high while cs_n (synchronized) is high.
